// File: rtl/stb_controller.sv
// Store-buffer control: LSU accept, occupancy tracking, DCache drain sequencing,
// fence/flush completion and a sticky DCache stall watchdog.
module stb_controller #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            lsudbus2stb_req,
  output logic                            stb2lsudbus_ack,
  input  logic                            flush_req,
  output logic                            stb_flush_done,
  output logic                            stb_busy,
  output logic                            wr_en,
  output logic                            rd_sel,
  output logic                            r_en,
  output logic                            stb_full,
  output logic                            stb_empty,
  output logic                            stb2dcache_req,
  output logic                            stb2dcache_w_en,
  input  logic                            dcache2stb_ack,
  output logic                            stb_timeout_err,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] stb_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_CNT  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic [TW-1:0] timer, timer_nxt;
  logic          err_nxt;
  logic          flush_pending;

  // Watchdog timer stops at the timeout value instead of wrapping.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (v >= TMO_CNT) ? TMO_CNT : v + TW'(1);
  endfunction

  assign stb_full        = (count == FULL_CNT);
  assign stb_empty       = (count == '0);
  assign wr_en           = lsudbus2stb_req & ~stb_full & ~flush_req;
  assign stb2lsudbus_ack = wr_en;
  assign stb2dcache_w_en = stb2dcache_req;
  assign stb_count       = count;
  assign stb_busy        = ~stb_empty | (state != IDLE);
  assign stb_flush_done  = flush_pending & stb_empty & (state == IDLE);

  always_comb begin
    state_nxt      = state;
    rd_sel         = 1'b0;
    stb2dcache_req = 1'b0;
    r_en           = 1'b0;
    timer_nxt      = '0;
    err_nxt        = stb_timeout_err;
    case (state)
      IDLE: begin
        if (!stb_empty) state_nxt = REQ;
      end
      REQ: begin
        rd_sel         = 1'b1;
        stb2dcache_req = 1'b1;
        if (dcache2stb_ack) begin
          r_en      = 1'b1;
          state_nxt = GAP;
        end else begin
          timer_nxt = sat_inc(timer);
          if (sat_inc(timer) == TMO_CNT) err_nxt = 1'b1;
        end
      end
      // GAP lets the datapath read pointer settle before the next request.
      GAP: begin
        state_nxt = stb_empty ? IDLE : REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      timer           <= '0;
      stb_timeout_err <= 1'b0;
      flush_pending   <= 1'b0;
    end else begin
      state           <= state_nxt;
      timer           <= timer_nxt;
      stb_timeout_err <= err_nxt;
      case ({wr_en, r_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      flush_pending <= stb_flush_done ? 1'b0 : (flush_pending | flush_req);
    end
  end

endmodule

// File: tb/tb_stb_controller.sv
// Scoreboard bench for stb_controller: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level occupancy/drain model.
module tb_stb_controller;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lsudbus2stb_req = 1'b0;
  logic          flush_req = 1'b0;
  logic          dcache2stb_ack = 1'b0;
  logic          stb2lsudbus_ack, stb_flush_done, stb_busy, wr_en, rd_sel, r_en;
  logic          stb_full, stb_empty, stb2dcache_req, stb2dcache_w_en, stb_timeout_err;
  logic [CW-1:0] stb_count;

  stb_controller #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .lsudbus2stb_req(lsudbus2stb_req), .stb2lsudbus_ack(stb2lsudbus_ack),
    .flush_req(flush_req), .stb_flush_done(stb_flush_done), .stb_busy(stb_busy),
    .wr_en(wr_en), .rd_sel(rd_sel), .r_en(r_en),
    .stb_full(stb_full), .stb_empty(stb_empty),
    .stb2dcache_req(stb2dcache_req), .stb2dcache_w_en(stb2dcache_w_en),
    .dcache2stb_ack(dcache2stb_ack), .stb_timeout_err(stb_timeout_err),
    .stb_count(stb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ack, wr, rsel, ren, full, empty, req, wen, done, busy, err;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: occupancy, drain phase (0 idle, 1 requesting, 2 settle gap),
  // cycles spent requesting since the last ack, sticky timeout, pending flush.
  int m_cnt, m_phase, m_reqcyc;
  bit m_err, m_pend;

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_reqcyc = 0; m_err = 0; m_pend = 0;
  endtask

  task automatic chk(input string n, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
    end
  endtask

  task automatic cycle(input bit lreq, input bit dack, input bit fl, input bit r);
    exp_t e;
    bit   wr, ren, done;
    @(posedge clk); #1;
    rst = r; lsudbus2stb_req = lreq; dcache2stb_ack = dack; flush_req = fl;
    if (r) model_reset();
    wr   = lreq && (m_cnt != DEPTH) && !fl;
    ren  = (m_phase == 1) && dack;
    done = m_pend && (m_cnt == 0) && (m_phase == 0);
    e.ack = wr; e.wr = wr; e.ren = ren;
    e.rsel = (m_phase == 1); e.req = (m_phase == 1); e.wen = (m_phase == 1);
    e.full = (m_cnt == DEPTH); e.empty = (m_cnt == 0);
    e.done = done; e.busy = (m_cnt != 0) || (m_phase != 0);
    e.err = m_err; e.cnt = m_cnt;
    sb.push_back(e);
    if (!r) begin
      case (m_phase)
        0: if (m_cnt != 0) m_phase = 1;
        1: if (dack) begin
             m_phase = 2; m_reqcyc = 0;
           end else begin
             m_reqcyc++;
             if (m_reqcyc >= TMO) m_err = 1;
           end
        default: m_phase = (m_cnt != 0) ? 1 : 0;
      endcase
      m_cnt  = m_cnt + int'(wr) - int'(ren);
      m_pend = done ? 1'b0 : (m_pend | fl);
    end
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_cnt != 0 || m_phase != 0) && n < 100) begin
      cycle(0, m_phase == 1, 0, 0);
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL drain_bound: count %0d still queued after %0d cycles", m_cnt, n);
    end
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("ack",   stb2lsudbus_ack, e.ack);
      chk("wr_en", wr_en,           e.wr);
      chk("rd_sel", rd_sel,         e.rsel);
      chk("r_en",  r_en,            e.ren);
      chk("full",  stb_full,        e.full);
      chk("empty", stb_empty,       e.empty);
      chk("dc_req", stb2dcache_req, e.req);
      chk("dc_wen", stb2dcache_w_en, e.wen);
      chk("flush_done", stb_flush_done, e.done);
      chk("busy",  stb_busy,        e.busy);
      chk("timeout_err", stb_timeout_err, e.err);
      chk("count", int'(stb_count), e.cnt);
      chk("push_at_full", int'(wr_en & stb_full), 0);
      chk("pop_at_empty", int'(r_en & stb_empty), 0);
    end
  end

  initial begin
    bit fl = 0;
    bit done_now;
    model_reset();

    // Reset then a single store, acked after two request cycles.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Simultaneous push/pop at count 2.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    drain();

    // Fill to full, refuse a 5th store, then push/pop at full.
    do_reset();
    repeat (4) cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    drain();

    // Flush with 3 entries queued; stores are offered throughout.
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      done_now = m_pend && m_cnt == 0 && m_phase == 0;
      cycle(!done_now, m_phase == 1, !done_now, 0);
      if (done_now) break;
    end
    repeat (3) cycle(0, 0, 0, 0);

    // Flush requested while already idle and empty.
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);

    // Watchdog: one entry, no ack for 12 cycles, then a late ack.
    do_reset();
    cycle(1, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    drain();

    // Asynchronous reset mid-request with 3 entries, then a stray ack.
    do_reset();
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);

    // Random traffic with occasional flush toggles and resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 31) == 0) fl = !fl;
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4, fl,
            $urandom_range(0, 499) == 0);
    end
    fl = 0;
    repeat (4) cycle(0, 0, 0, 0);

    @(posedge clk); #6;
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
